// File: rtl/cr_isf_stat_counter_bank_pkg.sv
// Shared definitions for the ISF statistics counter bank: GLBL register layout
// and register map strides.
package cr_isf_regfilePKG;

  localparam int GLBL_CLEAR_BIT  = 0;
  localparam int GLBL_FREEZE_BIT = 1;
  localparam int GLBL_SAT_BIT    = 2;
  localparam int GLBL_CLRRD_BIT  = 3;
  localparam int GLBL_OVF_LSB    = 16;

  localparam int CHAN_STRIDE = 8;
  localparam int HI_OFFSET   = 4;
  localparam int WORD_W      = 32;

  typedef struct packed {
    logic [15:0] ovf;
    logic [11:0] rsvd;
    logic        clr_on_rd;
    logic        saturate;
    logic        freeze;
    logic        clear_all;
  } stat_glbl_t;

endpackage

// File: rtl/cr_isf_stat_counter_bank_counter.sv
// One statistics channel: wide counter, HI snapshot taken on LO read, and a
// sticky overflow flag.
module cr_isf_stat_counter
  import cr_isf_regfilePKG::*;
#(
  parameter int N_CNT_BITS = 50,
  parameter int N_BY_BITS  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stb,
  input  logic [N_BY_BITS-1:0] by,
  input  logic                 freeze,
  input  logic                 sat,
  input  logic                 clr,
  input  logic                 snap_en,
  input  logic                 clr_rd,
  output logic [WORD_W-1:0]    lo_word,
  output logic [WORD_W-1:0]    hi_word,
  output logic                 ovf
);

  logic [N_CNT_BITS-1:0]        cnt;
  logic [N_CNT_BITS-WORD_W-1:0] snap_hi;
  logic                         inc;
  logic [N_CNT_BITS:0]          sum;

  function automatic logic [N_CNT_BITS-1:0] clamp_sum(input logic [N_CNT_BITS:0] s,
                                                      input logic sat_mode);
    if (s[N_CNT_BITS] && sat_mode) return '1;
    return s[N_CNT_BITS-1:0];
  endfunction

  assign inc = stb && !freeze;
  assign sum = {1'b0, cnt} + (N_CNT_BITS+1)'(by);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      snap_hi <= '0;
      ovf     <= 1'b0;
    end else if (clr) begin
      cnt     <= '0;
      snap_hi <= '0;
      ovf     <= 1'b0;
    end else begin
      // Only the upper bits are ever read back from the snapshot.
      if (snap_en) snap_hi <= cnt[N_CNT_BITS-1:WORD_W];
      if (clr_rd) begin
        cnt <= inc ? N_CNT_BITS'(by) : '0;
      end else if (inc) begin
        cnt <= clamp_sum(sum, sat);
        if (sum[N_CNT_BITS]) ovf <= 1'b1;
      end
    end
  end

  assign lo_word = cnt[WORD_W-1:0];
  assign hi_word = WORD_W'(snap_hi);

endmodule

// File: rtl/cr_isf_stat_counter_bank.sv
// Multi-channel statistics counter bank with LO/HI register read-back, atomic
// 64-bit reads via HI snapshot, and a global control/status register.
module cr_isf_stat_counter_bank
  import cr_isf_regfilePKG::*;
#(
  parameter int N_CHAN      = 4,
  parameter int N_CNT_BITS  = 50,
  parameter int N_BY_BITS   = 4,
  parameter int N_ADDR_BITS = 12,
  parameter int BASE_ADDR   = 'h100,
  parameter int GLBL_ADDR   = 'h0F0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_ADDR_BITS-1:0]        reg_addr,
  input  logic                          wr_stb,
  input  logic                          rd_stb,
  input  logic [31:0]                   reg_wr_data,
  input  logic [N_CHAN-1:0]             count_stb,
  input  logic [N_CHAN*N_BY_BITS-1:0]   count_by,
  output logic [31:0]                   rd_data,
  output logic                          rd_hit,
  output logic [N_CHAN-1:0]             ovf
);

  logic                          freeze_q, sat_q, clr_on_rd_q;
  logic                          glbl_sel, glbl_wr, clear_all;
  logic [N_CHAN-1:0]             lo_rd;
  logic [N_CHAN-1:0][WORD_W-1:0] lo_word, hi_word;
  logic [31:0]                   rd_mux;
  logic                          rd_any;
  stat_glbl_t                    glbl_rd;
  logic                          unused_wr_bits;

  assign unused_wr_bits = ^reg_wr_data[31:GLBL_CLRRD_BIT+1];

  assign glbl_sel  = (reg_addr == N_ADDR_BITS'(GLBL_ADDR));
  assign glbl_wr   = wr_stb && glbl_sel;
  assign clear_all = glbl_wr && reg_wr_data[GLBL_CLEAR_BIT];

  always_comb begin
    glbl_rd           = '0;
    glbl_rd.freeze    = freeze_q;
    glbl_rd.saturate  = sat_q;
    glbl_rd.clr_on_rd = clr_on_rd_q;
    glbl_rd.ovf       = 16'(ovf);
  end

  always_comb begin
    lo_rd  = '0;
    rd_mux = '0;
    rd_any = 1'b0;
    if (glbl_sel) begin
      rd_mux = glbl_rd;
      rd_any = 1'b1;
    end
    for (int i = 0; i < N_CHAN; i++) begin
      if (reg_addr == N_ADDR_BITS'(BASE_ADDR + CHAN_STRIDE*i)) begin
        lo_rd[i] = rd_stb;
        rd_mux   = lo_word[i];
        rd_any   = 1'b1;
      end
      if (reg_addr == N_ADDR_BITS'(BASE_ADDR + CHAN_STRIDE*i + HI_OFFSET)) begin
        rd_mux = hi_word[i];
        rd_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freeze_q    <= 1'b0;
      sat_q       <= 1'b0;
      clr_on_rd_q <= 1'b0;
      rd_data     <= '0;
      rd_hit      <= 1'b0;
    end else begin
      rd_hit <= rd_stb && rd_any;
      // GLBL reads sample the pre-write fields when a write lands in the same cycle.
      if (rd_stb && rd_any) rd_data <= rd_mux;
      if (glbl_wr) begin
        freeze_q    <= reg_wr_data[GLBL_FREEZE_BIT];
        sat_q       <= reg_wr_data[GLBL_SAT_BIT];
        clr_on_rd_q <= reg_wr_data[GLBL_CLRRD_BIT];
      end
    end
  end

  for (genvar i = 0; i < N_CHAN; i++) begin : g_chan
    cr_isf_stat_counter #(
      .N_CNT_BITS (N_CNT_BITS),
      .N_BY_BITS  (N_BY_BITS)
    ) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .stb     (count_stb[i]),
      .by      (count_by[i*N_BY_BITS +: N_BY_BITS]),
      .freeze  (freeze_q),
      .sat     (sat_q),
      .clr     (clear_all),
      .snap_en (lo_rd[i]),
      .clr_rd  (lo_rd[i] && clr_on_rd_q),
      .lo_word (lo_word[i]),
      .hi_word (hi_word[i]),
      .ovf     (ovf[i])
    );
  end

endmodule

// File: tb/tb_cr_isf_stat_counter_bank.sv
// Directed bench for the statistics counter bank, sized with a 33-bit counter
// and 32-bit increments so wrap/saturate boundaries are reachable quickly.
module tb_cr_isf_stat_counter_bank;

  localparam int NC = 4;
  localparam int CB = 33;
  localparam int BB = 32;
  localparam int AB = 12;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [AB-1:0]     reg_addr;
  logic              wr_stb, rd_stb;
  logic [31:0]       reg_wr_data;
  logic [NC-1:0]     count_stb;
  logic [NC*BB-1:0]  count_by;
  logic [31:0]       rd_data;
  logic              rd_hit;
  logic [NC-1:0]     ovf;

  int total = 0;
  int bad   = 0;
  logic [31:0] d, saved;
  logic        h;

  cr_isf_stat_counter_bank #(
    .N_CHAN(NC), .N_CNT_BITS(CB), .N_BY_BITS(BB), .N_ADDR_BITS(AB),
    .BASE_ADDR('h100), .GLBL_ADDR('h0F0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .reg_addr(reg_addr), .wr_stb(wr_stb), .rd_stb(rd_stb),
    .reg_wr_data(reg_wr_data), .count_stb(count_stb), .count_by(count_by),
    .rd_data(rd_data), .rd_hit(rd_hit), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [AB-1:0] lo(input int ch);
    return AB'('h100 + 8*ch);
  endfunction

  function automatic logic [AB-1:0] hi(input int ch);
    return AB'('h104 + 8*ch);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    wr_stb    = 1'b0;
    rd_stb    = 1'b0;
    count_stb = '0;
    count_by  = '0;
  endtask

  task automatic rd(input logic [AB-1:0] a, output logic [31:0] data, output logic hit);
    reg_addr = a;
    rd_stb   = 1'b1;
    step();
    data = rd_data;
    hit  = rd_hit;
  endtask

  task automatic wr(input logic [AB-1:0] a, input logic [31:0] v);
    reg_addr    = a;
    reg_wr_data = v;
    wr_stb      = 1'b1;
    step();
  endtask

  task automatic inc(input int ch, input logic [31:0] by);
    count_stb[ch]          = 1'b1;
    count_by[ch*BB +: BB]  = by;
    step();
  endtask

  initial begin
    rst_n = 1'b0; reg_addr = '0; wr_stb = 0; rd_stb = 0; reg_wr_data = '0;
    count_stb = '0; count_by = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_rd_data", rd_data, 32'h0);
    chk("reset_rd_hit", 32'(rd_hit), 32'h0);
    chk("reset_ovf", 32'(ovf), 32'h0);
    rst_n = 1'b1;
    step();

    // basic counting
    inc(0, 4); inc(0, 4); inc(0, 4);
    rd(lo(0), d, h); chk("lo0_12", d, 32'd12); chk("lo0_hit", 32'(h), 32'h1);
    rd(hi(0), d, h); chk("hi0_0", d, 32'h0);
    chk("ovf_none", 32'(ovf), 32'h0);
    rd(AB'('h0F0), d, h); chk("glbl_reset", d, 32'h0);

    // wrap: 2^33-2 + 5 -> 3
    inc(2, 32'hFFFF_FFFF); inc(2, 32'hFFFF_FFFF); inc(2, 5);
    chk("ovf_wrap", 32'(ovf), 32'h4);
    rd(lo(2), d, h); chk("lo2_wrap", d, 32'd3);
    rd(hi(2), d, h); chk("hi2_wrap", d, 32'h0);

    // saturate
    wr(AB'('h0F0), 32'h4);
    inc(3, 32'hFFFF_FFFF); inc(3, 32'hFFFF_FFFF); inc(3, 5);
    chk("ovf_sat", 32'(ovf), 32'hC);
    rd(lo(3), d, h); chk("lo3_sat", d, 32'hFFFF_FFFF);
    rd(hi(3), d, h); chk("hi3_sat", d, 32'h1);
    rd(AB'('h0F0), d, h); chk("glbl_sat", d, 32'h000C_0004);

    // clear_all alongside increments on every channel
    reg_addr = AB'('h0F0); reg_wr_data = 32'h1; wr_stb = 1'b1;
    count_stb = '1; count_by = {NC{32'd1}};
    step();
    chk("ovf_clr", 32'(ovf), 32'h0);
    rd(lo(0), d, h); chk("lo0_clr", d, 32'h0);
    rd(lo(2), d, h); chk("lo2_clr", d, 32'h0);
    rd(hi(3), d, h); chk("hi3_snap_clr", d, 32'h0);
    rd(AB'('h0F0), d, h); chk("glbl_clr", d, 32'h0);

    // snapshot atomicity
    inc(1, 32'hFFFF_FFFF);
    rd(lo(1), d, h); chk("lo1_atom", d, 32'hFFFF_FFFF);
    inc(1, 1);
    rd(hi(1), d, h); chk("hi1_atom", d, 32'h0);
    rd(lo(1), d, h); chk("lo1_after", d, 32'h0);
    rd(hi(1), d, h); chk("hi1_after", d, 32'h1);

    // clear-on-read with same-cycle increment
    inc(0, 9);
    wr(AB'('h0F0), 32'h8);
    reg_addr = lo(0); rd_stb = 1'b1;
    count_stb[0] = 1'b1; count_by[0 +: BB] = 32'd7;
    step();
    chk("cor_old", rd_data, 32'd9);
    wr(AB'('h0F0), 32'h0);
    rd(lo(0), d, h); chk("cor_new", d, 32'd7);

    // simultaneous read and write of GLBL
    reg_addr = AB'('h0F0); reg_wr_data = 32'h4; wr_stb = 1'b1; rd_stb = 1'b1;
    step();
    chk("rdwr_pre", rd_data, 32'h0);
    rd(AB'('h0F0), d, h); chk("rdwr_post", d, 32'h4);

    // freeze with random traffic
    wr(AB'('h0F0), 32'h2);
    for (int k = 0; k < 100; k++) begin
      count_stb = NC'($urandom);
      for (int c = 0; c < NC; c++) count_by[c*BB +: BB] = $urandom;
      step();
    end
    wr(AB'('h0F0), 32'h0);
    chk("frz_ovf", 32'(ovf), 32'h0);
    rd(lo(0), d, h); chk("frz_lo0", d, 32'd7);
    rd(hi(1), d, h); chk("frz_hi1", d, 32'h1);
    rd(lo(3), d, h); chk("frz_lo3", d, 32'h0);

    // writes to counter addresses are ignored; unmapped read holds rd_data
    wr(lo(0), 32'h55);
    rd(lo(0), d, h); chk("wr_ignored", d, 32'd7);
    saved = d;
    rd(AB'('h200), d, h);
    chk("unmapped_hit", 32'(h), 32'h0);
    chk("unmapped_hold", d, saved);

    // asynchronous reset mid-operation with a pending read
    inc(0, 3);
    reg_addr = lo(0); rd_stb = 1'b1; rst_n = 1'b0;
    step();
    chk("rst_mid_hit", 32'(rd_hit), 32'h0);
    chk("rst_mid_data", rd_data, 32'h0);
    rst_n = 1'b1;
    rd(lo(0), d, h); chk("rst_mid_cnt", d, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
